// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_if
// Brief   : Decode/execute to multiply-divide unit handshake and writeback bundle.
// Revision: 1.0
// ============================================================================
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [2:0]      opfunc3_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic [4:0]      rd_addr_i;
  logic            flush_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;
  logic [4:0]      rd_addr_o;
  logic            rd_we_o;

  modport master (
    output start_i, opfunc3_i, rs1_i, rs2_i, rd_addr_i, flush_i,
    input  busy_o, done_o, result_o, rd_addr_o, rd_we_o
  );

  modport slave (
    input  start_i, opfunc3_i, rs1_i, rs2_i, rd_addr_i, flush_i,
    output busy_o, done_o, result_o, rd_addr_o, rd_we_o
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_unit
// Brief   : Iterative RV32M multiply/divide, one bit per cycle, stalls pipe.
// Revision: 1.0
// ============================================================================
module muldiv_unit #(
  parameter int XLEN      = 32,
  parameter int DIV0_FAST = 1
) (
  input  logic     clk_i,
  input  logic     rst_i,
  muldiv_if.slave  bus
);

  localparam int                 c_cnt_w   = $clog2(XLEN);
  localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(XLEN - 1);
  localparam logic [XLEN-1:0]    c_int_min = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_cnt_w-1:0]  r_count;
  logic [2:0]          r_func;
  logic [4:0]          r_rd;
  logic [XLEN-1:0]     r_a;
  logic [XLEN-1:0]     r_b;
  logic                r_neg;
  logic                r_sa;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_result;
  logic [4:0]          r_rd_out;

  logic                w_accept;
  logic                w_a_signed;
  logic                w_b_signed;
  logic                w_sa;
  logic                w_sb;
  logic [XLEN-1:0]     w_abs_a;
  logic [XLEN-1:0]     w_abs_b;
  logic                w_div0;
  logic                w_ovf;
  logic                w_fast;
  logic [XLEN-1:0]     w_fast_res;
  logic [XLEN:0]       w_sum;
  logic [2*XLEN-1:0]   w_mul_nxt;
  logic [XLEN:0]       w_shift;
  logic [XLEN:0]       w_sub;
  logic [2*XLEN-1:0]   w_div_nxt;
  logic [2*XLEN-1:0]   w_acc_nxt;
  logic [2*XLEN-1:0]   w_prod;
  logic [XLEN-1:0]     w_quo;
  logic [XLEN-1:0]     w_rem;
  logic [XLEN-1:0]     w_calc_res;
  logic                w_busy;
  logic                w_done;

  assign w_accept = bus.start_i & ~bus.flush_i;

  always_comb begin
    w_a_signed = 1'b0;
    w_b_signed = 1'b0;
    case (bus.opfunc3_i)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        w_a_signed = 1'b1;
        w_b_signed = 1'b1;
      end
      3'b010:  w_a_signed = 1'b1;
      default: ;
    endcase
  end

  assign w_sa    = w_a_signed & bus.rs1_i[XLEN-1];
  assign w_sb    = w_b_signed & bus.rs2_i[XLEN-1];
  assign w_abs_a = w_sa ? -bus.rs1_i : bus.rs1_i;
  assign w_abs_b = w_sb ? -bus.rs2_i : bus.rs2_i;

  assign w_div0 = bus.opfunc3_i[2] & (bus.rs2_i == '0);
  assign w_ovf  = bus.opfunc3_i[2] & ~bus.opfunc3_i[0] &
                  (bus.rs1_i == c_int_min) & (bus.rs2_i == '1);
  assign w_fast = (DIV0_FAST != 0) && (w_div0 || w_ovf);

  always_comb begin
    if (bus.opfunc3_i[1]) w_fast_res = w_div0 ? bus.rs1_i : '0;
    else                  w_fast_res = w_div0 ? '1 : c_int_min;
  end

  // Shift-add: upper half accumulates, multiplier drains out of the lower half.
  assign w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_a} : '0);
  assign w_mul_nxt = {w_sum, r_acc[XLEN-1:1]};

  // Remainder stays below the divisor, so bit XLEN of the difference is the borrow.
  assign w_shift   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_sub     = w_shift - {1'b0, r_b};
  assign w_div_nxt = w_sub[XLEN] ? {w_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                 : {w_sub[XLEN-1:0],   r_acc[XLEN-2:0], 1'b1};

  assign w_acc_nxt = r_func[2] ? w_div_nxt : w_mul_nxt;
  assign w_prod    = r_neg ? -w_acc_nxt : w_acc_nxt;
  assign w_quo     = r_neg ? -w_acc_nxt[XLEN-1:0] : w_acc_nxt[XLEN-1:0];
  assign w_rem     = r_sa  ? -w_acc_nxt[2*XLEN-1:XLEN] : w_acc_nxt[2*XLEN-1:XLEN];

  always_comb begin
    case (r_func)
      3'b000:                 w_calc_res = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_calc_res = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_calc_res = w_quo;
      default:                w_calc_res = w_rem;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_busy      = 1'b1;
          w_state_nxt = w_fast ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        w_busy = 1'b1;
        if (bus.flush_i)           w_state_nxt = S_IDLE;
        else if (r_count == c_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_done      = ~bus.flush_i;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count  <= '0;
      r_func   <= '0;
      r_rd     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_neg    <= 1'b0;
      r_sa     <= 1'b0;
      r_acc    <= '0;
      r_result <= '0;
      r_rd_out <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_func  <= bus.opfunc3_i;
            r_rd    <= bus.rd_addr_i;
            r_a     <= w_abs_a;
            r_b     <= w_abs_b;
            // Zero divisor keeps the all-ones quotient unsigned-looking.
            r_neg   <= (w_sa ^ w_sb) & (bus.rs2_i != '0);
            r_sa    <= w_sa;
            r_count <= '0;
            r_acc   <= bus.opfunc3_i[2] ? {{XLEN{1'b0}}, w_abs_a}
                                        : {{XLEN{1'b0}}, w_abs_b};
            if (w_fast) begin
              r_result <= w_fast_res;
              r_rd_out <= bus.rd_addr_i;
            end
          end
        end
        S_CALC: begin
          if (!bus.flush_i) begin
            r_acc   <= w_acc_nxt;
            r_count <= r_count + c_cnt_w'(1);
            if (r_count == c_last) begin
              r_result <= w_calc_res;
              r_rd_out <= r_rd;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o    = w_busy;
  assign bus.done_o    = w_done;
  assign bus.rd_we_o   = w_done;
  assign bus.result_o  = r_result;
  assign bus.rd_addr_o = r_rd_out;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_muldiv_unit
// Brief   : Scoreboard bench for muldiv_unit: directed RV32M cases plus random ops.
// Revision: 1.0
// ============================================================================
module tb_muldiv_unit;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb_q[$];
  exp_t m_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_if #(.XLEN(32)) mif ();

  muldiv_unit #(.XLEN(32), .DIV0_FAST(1)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (mif.slave)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, p;
    logic [63:0]        up;
    logic               ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * $signed({32'b0, b}); return p[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : $signed(a) / $signed(b);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : $signed(a) % $signed(b);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 33;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    #2;
    if (mif.done_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_done", 32'(mif.done_o), 32'd0);
      end else begin
        m_e = sb_q.pop_front();
        check_eq("result", mif.result_o, m_e.res);
        check_eq("rd_addr", 32'(mif.rd_addr_o), 32'(m_e.rd));
        check_eq("rd_we", 32'(mif.rd_we_o), 32'd1);
        check_eq("done_cycle", 32'(cyc), 32'(m_e.cyc));
      end
    end
  end

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input bit inject);
    int   lat;
    exp_t e;
    @(negedge clk);
    mif.start_i   = 1'b1;
    mif.opfunc3_i = f;
    mif.rs1_i     = a;
    mif.rs2_i     = b;
    mif.rd_addr_i = rd;
    lat   = latency(f, a, b);
    e.res = exp;
    e.rd  = rd;
    e.cyc = cyc + lat;
    sb_q.push_back(e);
    #1 check_eq("busy_c0", 32'(mif.busy_o), 32'd1);
    for (int k = 1; k <= 45 && sb_q.size() != 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        mif.start_i   = 1'b0;
        mif.rs1_i     = $urandom;
        mif.rs2_i     = $urandom;
        mif.rd_addr_i = 5'(k + 17);
      end
      if (inject && k >= 5 && k <= 8) begin
        mif.start_i   = 1'b1;
        mif.opfunc3_i = 3'b100;
        mif.rs1_i     = $urandom;
        mif.rs2_i     = $urandom;
      end
      if (inject && k == 9) mif.start_i = 1'b0;
      #1 check_eq("busy", 32'(mif.busy_o), 32'(k < lat));
    end
    if (sb_q.size() != 0) begin
      check_eq("timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  task automatic check_cleared(input string tag);
    check_eq({tag, "_busy"}, 32'(mif.busy_o), 32'd0);
    check_eq({tag, "_done"}, 32'(mif.done_o), 32'd0);
    check_eq({tag, "_we"}, 32'(mif.rd_we_o), 32'd0);
    check_eq({tag, "_result"}, mif.result_o, 32'd0);
    check_eq({tag, "_rd"}, 32'(mif.rd_addr_o), 32'd0);
  endtask

  logic [2:0]  t_f  [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
  logic [31:0] t_a  [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                             32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] t_b  [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                             32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] t_ex [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                             32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    rst           = 1'b1;
    mif.start_i   = 1'b0;
    mif.opfunc3_i = 3'd0;
    mif.rs1_i     = '0;
    mif.rs2_i     = '0;
    mif.rd_addr_i = '0;
    mif.flush_i   = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_cleared("reset");
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_op(t_f[i], t_a[i], t_b[i], 5'(i + 1), t_ex[i], 1'b0);

    // Flush a divide at cycle 10, then a fresh multiply must run normally.
    @(negedge clk);
    mif.start_i   = 1'b1;
    mif.opfunc3_i = 3'b100;
    mif.rs1_i     = 32'd1000;
    mif.rs2_i     = 32'd3;
    mif.rd_addr_i = 5'd9;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1)  mif.start_i = 1'b0;
      if (k == 10) mif.flush_i = 1'b1;
    end
    @(negedge clk);
    mif.flush_i = 1'b0;
    #1 check_eq("busy_after_flush", 32'(mif.busy_o), 32'd0);
    repeat (35) @(negedge clk);
    run_op(3'b000, 32'd3, 32'd4, 5'd12, 32'd12, 1'b0);

    // Reset in the middle of a multiply.
    @(negedge clk);
    mif.start_i   = 1'b1;
    mif.opfunc3_i = 3'b000;
    mif.rs1_i     = 32'd11;
    mif.rs2_i     = 32'd13;
    mif.rd_addr_i = 5'd7;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1)  mif.start_i = 1'b0;
      if (k == 20) rst = 1'b1;
    end
    @(negedge clk);
    #1 check_cleared("midrst");
    rst = 1'b0;
    repeat (40) @(negedge clk);

    run_op(3'b000, 32'd1234, 32'd5678, 5'd3, 32'd7006652, 1'b1);

    for (int i = 0; i < 10; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i % 4 == 0) ? 32'd0 : $urandom;
      if (i == 5) begin
        rf = 3'b100;
        ra = 32'h8000_0000;
        rb = 32'hFFFF_FFFF;
      end
      run_op(rf, ra, rb, 5'(i), model(rf, ra, rb), 1'b0);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
